call_stack: RTL

- Hardware return-address stack for the 8-bit microcontroller.
- Sits directly upstream of the PC register.
  - On CALL, the control unit pushes the return address (PC+1, the output of the 10-bit adder).
  - On RET, it pops. top_addr feeds the PC next-address mux.
- Holds up to DEPTH 10-bit addresses with full/empty status and sticky error flags.

---
 rtl/call_stack_pkg.sv | 19 +
 rtl/call_stack_mem.sv | 26 ++
 rtl/call_stack.sv | 110 +++++++++++
 3 files changed

// File: rtl/call_stack_pkg.sv
// Shared definitions for the return-address stack: default sizes and the
// push/pop operation encoding that the control unit drives.
package call_stack_pkg;

  localparam int ADDR_W      = 10;
  localparam int STACK_DEPTH = 8;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_REPL = 2'b11
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic push, input logic pop);
    return stack_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/call_stack_mem.sv
// DEPTH x AW storage: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module call_stack_mem
  import call_stack_pkg::*;
#(
  parameter int AW    = ADDR_W,
  parameter int DEPTH = STACK_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [AW-1:0] wdata,
  input  logic [PW-1:0] raddr,
  output logic [AW-1:0] rdata
);

  logic [DEPTH-1:0][AW-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack.sv
// Hardware return-address stack feeding the PC next-address mux.
// Define CALL_STACK_WRAP_EN to make a push while full overwrite the oldest entry.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int AW    = ADDR_W,
  parameter int DEPTH = STACK_DEPTH,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_addr,
  input  logic          clr_err,
  output logic [AW-1:0] top_addr,
  output logic [PW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [PW:0] CNT_MAX = (PW+1)'(DEPTH);

  logic [PW-1:0] sp, sp_nxt, sp_top;
  logic [PW:0]   count_nxt;
  logic          we;
  logic [PW-1:0] waddr;
  logic          ovf_evt, unf_evt;
  logic [AW-1:0] rdata;
  stack_op_e     op;

  assign op     = decode_op(push, pop);
  assign empty  = (count == '0);
  assign full   = (count == CNT_MAX);
  assign sp_top = sp - PW'(1);

  always_comb begin
    sp_nxt    = sp;
    count_nxt = count;
    we        = 1'b0;
    waddr     = sp;
    ovf_evt   = 1'b0;
    unf_evt   = 1'b0;
    unique case (op)
      OP_PUSH: begin
        if (!full) begin
          we        = 1'b1;
          sp_nxt    = sp + PW'(1);
          count_nxt = count + 1'b1;
        end else begin
          ovf_evt = 1'b1;
`ifdef CALL_STACK_WRAP_EN
          // Circular overwrite: sp advances, count pinned at DEPTH.
          we     = 1'b1;
          sp_nxt = sp + PW'(1);
`endif
        end
      end
      OP_POP: begin
        if (!empty) begin
          sp_nxt    = sp_top;
          count_nxt = count - 1'b1;
        end else begin
          unf_evt = 1'b1;
        end
      end
      OP_REPL: begin
        if (!empty) begin
          we    = 1'b1;
          waddr = sp_top;
        end else begin
          // Nothing to pop: behave as a plain push but flag the bad pop.
          we        = 1'b1;
          sp_nxt    = sp + PW'(1);
          count_nxt = count + 1'b1;
          unf_evt   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_nxt;
      count     <= count_nxt;
      overflow  <= ovf_evt | (overflow & ~clr_err);
      underflow <= unf_evt | (underflow & ~clr_err);
    end
  end

  call_stack_mem #(.AW(AW), .DEPTH(DEPTH), .PW(PW)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (push_addr),
    .raddr (sp_top),
    .rdata (rdata)
  );

  assign top_addr = empty ? '0 : rdata;

endmodule
